product_bcd_converter: RTL and testbench
========================================

Name: product_bcd_converter

Overview:
Downstream consumer of the 8x8 multiplier's 16-bit product {A,B}. Converts the product into sign plus five BCD digits for the hex-display drivers, using a sequential shift-add-3 (double-dabble) engine. Operates as signed two's complement or unsigned, selected per conversion. A start/busy/done handshake lets the control logic request a conversion once the multiplier's run completes.

Parameters:
WIDTH, 16, product bit width; must equal 2x the multiplier operand width.
DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^WIDTH.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
start  input  1  conversion request; sampled only in IDLE.
signed_mode  input  1  1 = treat product as two's complement; 0 = unsigned. Sampled with start.
product  input  WIDTH  value to convert, e.g. {A,B} from the multiplier. Sampled with start.
busy  output  1  high from the cycle after accepted start until done is asserted.
done  output  1  one-cycle pulse; bcd and neg are valid from this cycle on.
neg  output  1  sign of the last completed result.
bcd  output  4*DIGITS  last completed result, digit 0 in bits [3:0], ascending significance.

Behaviour:
- Reset: reset=0 at a rising edge gives state IDLE, busy=0, done=0, neg=0, bcd=0, and clears all internal registers.
  - Reset overrides every other input, including mid-conversion. The partial result is discarded and is never published.
- States and transitions:
  - IDLE -> CONV on start=1.
  - CONV -> CONV while the iteration counter is below WIDTH-1.
  - CONV -> FINISH when the counter reaches WIDTH-1.
  - FINISH -> IDLE unconditionally.
- Accept (edge with IDLE and start=1):
  - If signed_mode=1 and product[WIDTH-1]=1: magnitude register = two's-complement negation of product, taken as unsigned WIDTH bits. Pending sign = 1.
  - Otherwise: magnitude = product, pending sign = 0.
  - Working BCD register cleared, counter = 0, busy=1 from the next cycle.
  - Most-negative input (0x8000 signed) gives magnitude 32768; no overflow.
- Each CONV cycle:
  - Every working digit >= 5 gets +3 (combinational correction).
  - Then the {bcd_work, magnitude} concatenation shifts left one bit, taking the magnitude MSB into digit 0 LSB.
  - Counter increments.
  - Exactly WIDTH CONV cycles per conversion.
- FINISH: bcd <= working register, neg <= pending sign, done=1 for this cycle only, busy=0.
- Latency: start accepted at edge E0, done high during the cycle after edge E0+WIDTH+1. That is WIDTH+2 cycles, 18 for defaults.
- Outputs bcd and neg hold the previous result throughout a conversion and change only in FINISH.
- start while busy (CONV or FINISH) is ignored, not queued. product and signed_mode may change freely after accept.
- start held high continuously: a new conversion is accepted on the IDLE cycle immediately after FINISH. Back-to-back throughput is one result per WIDTH+2 cycles.
- No X propagation: all registers have reset values, and the case statement has a default returning to IDLE.

Decomposition:
- Shared package product_bcd_pkg holds:
  - enum conv_state_t {IDLE, CONV, FINISH};
  - localparams for the counter width $clog2(WIDTH) and BCD_W = 4*DIGITS.
- One natural sub-module: bcd_add3, a combinational 4-bit digit corrector (in >= 5 ? in+3 : in), instantiated DIGITS times via generate.

Test Plan:
- Reset, then start with product=0x3039, signed_mode=0 -> done after 18 cycles, bcd=0x12345, neg=0, busy high exactly 17 cycles.
- product=0xFFFF with signed_mode=1 -> bcd=0x00001, neg=1. Same value with signed_mode=0 -> bcd=0x65535, neg=0.
- product=0x8000, signed_mode=1 -> bcd=0x32768, neg=1. product=0x0000 -> bcd=0x00000, neg=0.
- Start 0x0064 (bcd=0x00100). Pulse start with 0x0001 at cycle 5 of the conversion -> second request ignored, single done, bcd=0x00100. bcd unchanged before FINISH.
- Complete 0x3039, then start 0x0007 and assert reset=0 at cycle 8 -> next edge busy=0, done=0, bcd=0, neg=0, and no done pulse follows.
- start held high, alternating inputs 0x0009 and 0xFFF6 (signed) -> done pulses every 18 cycles, results 0x00009/neg=0 then 0x00010/neg=1.

Source files
------------

// File: rtl/product_bcd_converter_pkg.sv
// Shared types and default sizing for the product-to-BCD converter.
// WIDTH is the multiplier product width; DIGITS must satisfy 10^DIGITS > 2^WIDTH.
package product_bcd_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DIGITS = 5;
    localparam int CNT_W      = $clog2(DEF_WIDTH);
    localparam int BCD_W      = 4 * DEF_DIGITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        FINISH = 2'd2
    } conv_state_t;

endpackage

// File: rtl/product_bcd_converter_if.sv
// Conversion request/result bundle between the control logic (master)
// and the BCD converter (slave).
interface product_bcd_if
    import product_bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
);
    logic                  start;
    logic                  signed_mode;
    logic [WIDTH-1:0]      product;
    logic                  busy;
    logic                  done;
    logic                  neg;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output start, signed_mode, product,
        input  busy, done, neg, bcd
    );

    modport slave (
        input  start, signed_mode, product,
        output busy, done, neg, bcd
    );
endinterface

// File: rtl/product_bcd_converter_add3.sv
// Double-dabble digit corrector: a digit of 5 or more gets +3 before
// the shift so that it carries correctly into the next decade.
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);
    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;
endmodule

// File: rtl/product_bcd_converter.sv
// Sequential shift-add-3 converter: signed/unsigned product to sign plus
// BCD digits, one bit per cycle, start/busy/done handshake.
module product_bcd_converter
    import product_bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic          clk,
    input  logic          reset,
    product_bcd_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = 4 * DIGITS;

    conv_state_t         r_state, w_state_next;
    logic [WIDTH-1:0]    r_mag, w_mag_next;
    logic [BW-1:0]       r_work, w_work_next, w_work_adj;
    logic [CW-1:0]       r_cnt, w_cnt_next;
    logic                r_sign, w_sign_next;
    logic                r_done, w_done_next;
    logic                r_neg, w_neg_next;
    logic [BW-1:0]       r_bcd, w_bcd_next;
    logic [BW+WIDTH-1:0] w_shift;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_add3 u_add3 (
                .i_digit (r_work[gi*4 +: 4]),
                .o_digit (w_work_adj[gi*4 +: 4])
            );
        end
    endgenerate

    // Corrected digits and magnitude shift as one register; MSB drops out.
    assign w_shift = {w_work_adj, r_mag} << 1;

    always_comb begin
        w_state_next = r_state;
        w_mag_next   = r_mag;
        w_work_next  = r_work;
        w_cnt_next   = r_cnt;
        w_sign_next  = r_sign;
        w_done_next  = 1'b0;
        w_neg_next   = r_neg;
        w_bcd_next   = r_bcd;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = CONV;
                    w_work_next  = '0;
                    w_cnt_next   = '0;
                    if (bus.signed_mode && bus.product[WIDTH-1]) begin
                        w_mag_next  = ~bus.product + 1'b1;
                        w_sign_next = 1'b1;
                    end else begin
                        w_mag_next  = bus.product;
                        w_sign_next = 1'b0;
                    end
                end
            end
            CONV: begin
                w_work_next = w_shift[BW+WIDTH-1 -: BW];
                w_mag_next  = w_shift[WIDTH-1:0];
                w_cnt_next  = r_cnt + 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_next = FINISH;
                end
            end
            FINISH: begin
                w_bcd_next   = r_work;
                w_neg_next   = r_sign;
                w_done_next  = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_mag   <= '0;
            r_work  <= '0;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_done  <= 1'b0;
            r_neg   <= 1'b0;
            r_bcd   <= '0;
        end else begin
            r_state <= w_state_next;
            r_mag   <= w_mag_next;
            r_work  <= w_work_next;
            r_cnt   <= w_cnt_next;
            r_sign  <= w_sign_next;
            r_done  <= w_done_next;
            r_neg   <= w_neg_next;
            r_bcd   <= w_bcd_next;
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
    assign bus.neg  = r_neg;
    assign bus.bcd  = r_bcd;
endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed bench for product_bcd_converter: latency, sign handling,
// ignored start, mid-conversion reset and back-to-back throughput.
module tb_product_bcd_converter;
    import product_bcd_pkg::*;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    product_bcd_if #(.WIDTH(16), .DIGITS(5)) bus ();

    product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one conversion; reports latency (cycles after accept until done),
    // busy-high cycle count and whether the wait expired.
    task automatic run_conv(input logic [15:0] p, input logic m,
                            output int lat, output int busy_cnt, output bit timeout);
        bus.start       = 1'b1;
        bus.product     = p;
        bus.signed_mode = m;
        tick();
        bus.start = 1'b0;
        lat       = 0;
        busy_cnt  = 0;
        timeout   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            lat++;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                timeout = 1'b0;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.neg !== 1'b0 || bus.bcd !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b neg=%b bcd=%05h, required 0 0 0 00000",
                     bus.busy, bus.done, bus.neg, bus.bcd);
        end
        reset = 1'b1;
        tick();
        $display("[TB] reset: busy=%b done=%b bcd=%05h", bus.busy, bus.done, bus.bcd);
    endtask

    task automatic test_unsigned_basic();
        int lat, bc;
        bit to;
        run_conv(16'h3039, 1'b0, lat, bc, to);
        tests_run++;
        if (to || lat != 18) begin
            tests_failed++;
            $display("FAIL latency_3039: got %0d cycles (timeout=%0b), required 18", lat, to);
        end
        tests_run++;
        if (bc != 17) begin
            tests_failed++;
            $display("FAIL busy_cycles_3039: got %0d, required 17", bc);
        end
        tests_run++;
        if (bus.bcd !== 20'h12345 || bus.neg !== 1'b0) begin
            tests_failed++;
            $display("FAIL result_3039: got bcd=%05h neg=%b, required 12345 0", bus.bcd, bus.neg);
        end
        $display("[TB] 0x3039 unsigned -> bcd=%05h neg=%b lat=%0d busy=%0d", bus.bcd, bus.neg, lat, bc);
    endtask

    task automatic test_signs();
        logic [15:0] p_tab [4] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h0000};
        logic        m_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [19:0] b_tab [4] = '{20'h00001, 20'h65535, 20'h32768, 20'h00000};
        logic        n_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int lat, bc;
        bit to;
        for (int k = 0; k < 4; k++) begin
            run_conv(p_tab[k], m_tab[k], lat, bc, to);
            tests_run++;
            if (to || bus.bcd !== b_tab[k] || bus.neg !== n_tab[k]) begin
                tests_failed++;
                $display("FAIL sign_case_%0d: product=%04h mode=%b got bcd=%05h neg=%b timeout=%0b, required %05h %b",
                         k, p_tab[k], m_tab[k], bus.bcd, bus.neg, to, b_tab[k], n_tab[k]);
            end
            $display("[TB] %04h mode=%b -> bcd=%05h neg=%b", p_tab[k], m_tab[k], bus.bcd, bus.neg);
        end
    endtask

    task automatic test_ignore_start();
        int lat, bc, dones, held_bad;
        bit to;
        run_conv(16'hFFFF, 1'b0, lat, bc, to);
        bus.start       = 1'b1;
        bus.product     = 16'h0064;
        bus.signed_mode = 1'b0;
        tick();
        bus.start = 1'b0;
        dones     = 0;
        held_bad  = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c == 5) begin
                bus.start   = 1'b1;
                bus.product = 16'h0001;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) dones++;
            if (c < 18 && (bus.bcd !== 20'h65535 || bus.neg !== 1'b0)) held_bad++;
            if (c == 18) begin
                tests_run++;
                if (bus.done !== 1'b1 || bus.bcd !== 20'h00100) begin
                    tests_failed++;
                    $display("FAIL ignore_result: done=%b bcd=%05h, required 1 00100", bus.done, bus.bcd);
                end
            end
            tick();
        end
        tests_run++;
        if (held_bad != 0) begin
            tests_failed++;
            $display("FAIL ignore_hold: outputs changed in %0d cycles before finish, required 0", held_bad);
        end
        tests_run++;
        if (dones != 1 || bus.bcd !== 20'h00100) begin
            tests_failed++;
            $display("FAIL ignore_single_done: got %0d done pulses bcd=%05h, required 1 00100", dones, bus.bcd);
        end
        $display("[TB] ignored start: dones=%0d bcd=%05h", dones, bus.bcd);
    endtask

    task automatic test_reset_mid();
        int lat, bc, dones;
        bit to;
        run_conv(16'h3039, 1'b0, lat, bc, to);
        bus.start       = 1'b1;
        bus.product     = 16'h0007;
        bus.signed_mode = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd !== 20'h0 || bus.neg !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_state: busy=%b done=%b bcd=%05h neg=%b, required 0 0 00000 0",
                     bus.busy, bus.done, bus.bcd, bus.neg);
        end
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.done || bus.busy) dones++;
            tick();
        end
        tests_run++;
        if (dones != 0 || bus.bcd !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_no_done: %0d busy/done cycles bcd=%05h, required 0 00000", dones, bus.bcd);
        end
        $display("[TB] reset mid-conversion: bcd=%05h activity=%0d", bus.bcd, dones);
    endtask

    task automatic test_back_to_back();
        int  seen, last_c, prev_busy;
        logic [19:0] exp_b;
        logic        exp_n;
        seen      = 0;
        last_c    = -1;
        prev_busy = 0;
        bus.start       = 1'b1;
        bus.product     = 16'h0009;
        bus.signed_mode = 1'b1;
        for (int c = 0; c < 120 && seen < 4; c++) begin
            tick();
            if (bus.busy && prev_busy == 0)
                bus.product = (bus.product == 16'h0009) ? 16'hFFF6 : 16'h0009;
            prev_busy = bus.busy;
            if (bus.done) begin
                exp_b = (seen % 2 == 0) ? 20'h00009 : 20'h00010;
                exp_n = (seen % 2 == 0) ? 1'b0 : 1'b1;
                tests_run++;
                if (bus.bcd !== exp_b || bus.neg !== exp_n) begin
                    tests_failed++;
                    $display("FAIL b2b_result_%0d: got bcd=%05h neg=%b, required %05h %b",
                             seen, bus.bcd, bus.neg, exp_b, exp_n);
                end
                if (last_c >= 0) begin
                    tests_run++;
                    if (c - last_c != 18) begin
                        tests_failed++;
                        $display("FAIL b2b_interval_%0d: got %0d cycles, required 18", seen, c - last_c);
                    end
                end
                $display("[TB] b2b done %0d at cycle %0d: bcd=%05h neg=%b", seen, c, bus.bcd, bus.neg);
                last_c = c;
                seen++;
            end
        end
        bus.start = 1'b0;
        tests_run++;
        if (seen != 4) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d done pulses, required 4", seen);
        end
        tick();
        tick();
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        reset           = 1'b0;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.product     = '0;
        test_reset();
        test_unsigned_basic();
        test_signs();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
